// File: rtl/memory_controller.sv
// Bridges the control unit's rd_en/wr_en/busy handshake to a single-port byte-write RAM; lane alignment and read-latency sequencing.
// Read: busy for READ_LATENCY+1 cycles; write: 1 cycle; requests ignored while busy. Optional MEM_CTRL_MISALIGN_CHECK_EN rejects lane overflow.
module memory_controller #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         rd_en,
    input  logic                                         wr_en,
    input  logic [DATA_WIDTH/8-1:0]                      byte_en,
    input  logic [ADDR_WIDTH-1:0]                        addr,
    input  logic [DATA_WIDTH-1:0]                        wr_data,
    output logic [DATA_WIDTH-1:0]                        rd_data,
    output logic                                         busy,
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    output logic                                         misaligned,
`endif
    output logic                                         ram_en,
    output logic                                         ram_we,
    output logic [DATA_WIDTH/8-1:0]                      ram_byte_we,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]                        ram_wdata,
    input  logic [DATA_WIDTH-1:0]                        ram_rdata
);
    localparam int BYTE_NUM = DATA_WIDTH / 8;
    localparam int OFFSET   = $clog2(BYTE_NUM);
    localparam int CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [BYTE_NUM-1:0]   be_q, be_d;
    logic                  we_q, we_d;

    logic [OFFSET-1:0]     off;
    logic [BYTE_NUM-1:0]   lane_mask;
    logic [DATA_WIDTH-1:0] rd_mask;
    logic                  lane_ovf;
    logic                  issue_go;

    assign off = addr_q[OFFSET-1:0];

`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    // Shift into a double-width vector so lanes pushed past the word are visible.
    logic [2*BYTE_NUM-1:0] lane_wide;
    assign lane_wide = {{BYTE_NUM{1'b0}}, be_q} << off;
    assign lane_mask = lane_wide[BYTE_NUM-1:0];
    assign lane_ovf  = |lane_wide[2*BYTE_NUM-1:BYTE_NUM];
`else
    assign lane_mask = be_q << off;
    assign lane_ovf  = 1'b0;
`endif

    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < BYTE_NUM; i++) begin
            rd_mask[8*i +: 8] = {8{be_q[i]}};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = we_q;
        case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    addr_d  = addr;
                    wdata_d = wr_data;
                    be_d    = byte_en;
                    we_d    = wr_en;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (lane_ovf || we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rd_data_d = (ram_rdata >> {off, 3'b000}) & rd_mask;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            we_q      <= we_d;
            rd_data_q <= rd_data_d;
        end
    end

    // RAM side is decoded from state and the captured request only.
    assign issue_go    = (state_q == ISSUE) && !lane_ovf;
    assign busy        = (state_q == ISSUE) || (state_q == WAIT);
    assign ram_en      = issue_go;
    assign ram_we      = issue_go && we_q;
    assign ram_byte_we = (issue_go && we_q) ? lane_mask : '0;
    assign ram_addr    = addr_q[ADDR_WIDTH-1:OFFSET];
    assign ram_wdata   = wdata_q << {off, 3'b000};
    assign rd_data     = rd_data_q;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    assign misaligned  = (state_q == RESP) && lane_ovf;
`endif

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: directed requests, a RAM model and a transaction-level reference.
module tb_memory_controller;
    localparam int RL = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        rd_en, wr_en;
    logic [3:0]  byte_en;
    logic [31:0] addr, wr_data;
    logic [31:0] rd_data;
    logic        busy;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    logic        misaligned;
`endif
    logic        ram_en, ram_we;
    logic [3:0]  ram_byte_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    memory_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset), .rd_en(rd_en), .wr_en(wr_en),
        .byte_en(byte_en), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy),
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
        .misaligned(misaligned),
`endif
        .ram_en(ram_en), .ram_we(ram_we), .ram_byte_we(ram_byte_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM with RL-cycle read latency
    logic [31:0] mem [256];
    logic [31:0] p0, p1;
    assign ram_rdata = p1;
    always @(posedge clock) begin
        logic [31:0] w;
        w = mem[ram_addr[7:0]];
        if (ram_en && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_byte_we[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
            mem[ram_addr[7:0]] <= w;
        end
        if (ram_en && !ram_we) p0 <= mem[ram_addr[7:0]];
        p1 <= p0;
    end

    // Reference: timeline of each accepted request, golden memory updated at acceptance
    logic [31:0] gold [256];
    int          ph = 0, tot = 0, m_off = 0, m_word = 0;
    logic [31:0] m_addr = 0;
    logic [3:0]  m_be = 0, m_lanes = 0;
    logic        m_rd = 1'b0, m_ovf = 1'b0;
    logic [31:0] exp_rd = 0;

    function automatic logic ovf_model(input logic [3:0] be, input int o);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
        return (int'(be) << o) > 15;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            ph = 0;
            exp_rd = 0;
        end else if (ph == 0) begin
            if (rd_en || wr_en) begin
                logic [7:0] t;
                m_addr = addr;
                m_off  = int'(addr[1:0]);
                m_word = int'(addr[9:2]);
                m_be   = byte_en;
                m_rd   = !wr_en;
                m_ovf  = ovf_model(byte_en, m_off);
                t      = {4'b0, byte_en} << m_off;
                m_lanes = t[3:0];
                tot    = (m_rd && !m_ovf) ? RL + 2 : 2;
                if (!m_rd && !m_ovf)
                    for (int b = 0; b < 4; b++)
                        if (b >= m_off)
                            if (m_be[b-m_off]) gold[m_word][8*b +: 8] = wr_data[8*(b-m_off) +: 8];
                ph = 1;
            end
        end else if (ph == tot) begin
            ph = 0;
        end else begin
            ph++;
            if (ph == tot && m_rd && !m_ovf) begin
                exp_rd = 0;
                for (int b = 0; b < 4; b++)
                    if (m_be[b] && b + m_off < 4) exp_rd[8*b +: 8] = gold[m_word][8*(b+m_off) +: 8];
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_on) begin
            chk("busy", 32'(busy), 32'(ph >= 1 && ph < tot));
            chk("ram_en", 32'(ram_en), 32'(ph == 1 && !m_ovf));
            chk("ram_we", 32'(ram_we), 32'(ph == 1 && !m_ovf && !m_rd));
            chk("ram_byte_we", 32'(ram_byte_we), (ph == 1 && !m_ovf && !m_rd) ? 32'(m_lanes) : 32'h0);
            if (ph == 1) chk("ram_addr", {2'b0, ram_addr}, m_addr >> 2);
            chk("rd_data", rd_data, exp_rd);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
            chk("misaligned", 32'(misaligned), 32'(ph != 0 && ph == tot && m_ovf));
`endif
        end
    end

    // Directed driver
    logic [31:0] iss_addr, iss_wdata;
    logic [3:0]  iss_bwe;
    logic        iss_en, iss_we, resp_mis;
    int          bcnt;

    task automatic req(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        int guard;
        @(negedge clock);
        rd_en = r; wr_en = w; addr = a; wr_data = d; byte_en = be;
        @(negedge clock);
        iss_addr = {2'b0, ram_addr}; iss_wdata = ram_wdata; iss_bwe = ram_byte_we;
        iss_en = ram_en; iss_we = ram_we;
        bcnt = 0; guard = 0;
        while (busy && guard < 20) begin
            bcnt++; guard++;
            @(negedge clock);
        end
        if (guard >= 20) chk("busy_fall_timeout", 32'(busy), 32'h0);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
        resp_mis = misaligned;
`else
        resp_mis = 1'b0;
`endif
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int guard;
        reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        addr = 0; wr_data = 0; byte_en = 0;
        repeat (3) @(negedge clock);
        cmp_on = 1'b1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_ram_byte_we", 32'(ram_byte_we), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        reset = 1'b1;

        req(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        chk("preload_busy_cycles", bcnt, 1);

        req(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        chk("word_rd_ram_addr", iss_addr, 32'h40);
        chk("word_rd_busy_cycles", bcnt, 3);
        chk("word_rd_data", rd_data, 32'hDEADBEEF);

        req(1'b1, 1'b0, 32'h103, 32'h0, 4'h1);
        chk("byte_rd_data", rd_data, 32'h000000DE);

        req(1'b0, 1'b1, 32'h102, 32'h0000ABCD, 4'h3);
        chk("half_wr_bwe", 32'(iss_bwe), 32'hC);
        chk("half_wr_wdata", iss_wdata, 32'hABCD0000);
        chk("half_wr_busy_cycles", bcnt, 1);
        chk("half_wr_rd_hold", rd_data, 32'h000000DE);

        req(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        chk("half_wr_readback", rd_data, 32'hABCDBEEF);

        // Reset during WAIT, request kept asserted across release
        @(negedge clock);
        rd_en = 1'b1; addr = 32'h100; byte_en = 4'hF;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ram_en", 32'(ram_en), 32'h0);
        chk("midrst_rd_data", rd_data, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("postrst_accept_busy", 32'(busy), 32'h1);
        guard = 0;
        while (busy && guard < 20) begin guard++; @(negedge clock); end
        if (guard >= 20) chk("postrst_timeout", 32'(busy), 32'h0);
        rd_en = 1'b0;
        chk("postrst_rd_data", rd_data, 32'hABCDBEEF);

        req(1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF);
        chk("rdwr_ram_we", 32'(iss_we), 32'h1);
        chk("rdwr_bwe", 32'(iss_bwe), 32'hF);
        req(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        chk("rdwr_readback", rd_data, 32'h12345678);

        req(1'b1, 1'b0, 32'h102, 32'h0, 4'hF);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
        chk("misalign_flag", 32'(resp_mis), 32'h1);
        chk("misalign_no_ram_en", 32'(iss_en), 32'h0);
        chk("misalign_rd_hold", rd_data, 32'h12345678);
`else
        chk("misalign_ram_en", 32'(iss_en), 32'h1);
        chk("misalign_flag_absent", 32'(resp_mis), 32'h0);
        chk("misalign_trunc_data", rd_data, 32'h00001234);
`endif

        req(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        chk("be0_rd_data", rd_data, 32'h0);
        req(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0);
        chk("be0_wr_bwe", 32'(iss_bwe), 32'h0);
        req(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        chk("be0_wr_no_change", rd_data, 32'h12345678);

        req(1'b0, 1'b1, 32'h101, 32'h00000055, 4'h1);
        chk("byte_wr_bwe", 32'(iss_bwe), 32'h2);
        req(1'b1, 1'b0, 32'h101, 32'h0, 4'h3);
        chk("half_rd_off1", rd_data, 32'h00003455);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
